// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7_scan_ctrl display scanner: register offsets,
// CTRL bit positions, segment bit indices and the active-high hex lookup.
package seg7_pkg;

    typedef enum logic {
        MODE_IDLE = 1'b0,
        MODE_SCAN = 1'b1
    } scan_mode_t;

    localparam int CTRL_W       = 2;
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_HEX_BIT = 1;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Control registers sit directly above the digit registers.
    function automatic int off_ctrl(input int num_digits);
        return num_digits;
    endfunction

    function automatic int off_div(input int num_digits);
        return num_digits + 1;
    endfunction

    function automatic int off_blink(input int num_digits);
        return num_digits + 2;
    endfunction

    function automatic int idx_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

    function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Purely combinational nibble to a..g segment decoder (active-high segments).
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex7seg(nibble_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Avalon-MM multiplexed 7-segment scanner with programmable prescaler.
// Define SEG7_BLINK_EN to add the per-digit blink mask and frame divisor.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int               NUM_DIGITS     = 4,
    parameter int               ADDR_W         = 4,
    parameter int               DIV_W          = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV    = DIV_W'(49999),
    parameter bit               SEG_ACTIVE_LOW = 1'b1,
    parameter bit               DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_tick
);

    localparam int               IDX_W    = idx_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [7:0]            digit_q [NUM_DIGITS];
    logic [CTRL_W-1:0]     ctrl_q;
    logic [DIV_W-1:0]      div_q;
    logic [DIV_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wrap_q, wrap_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  tick_q, tick_d;
    logic                  wr_en, blank;
    int                    addr_int;
    scan_mode_t            mode;
    logic [7:0]            digit_sel;
    logic [6:0]            hex_seg;
    logic                  unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign addr_int     = int'(address);
    assign mode         = scan_mode_t'(ctrl_q[CTRL_EN_BIT]);
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the digit array is only a few flops, so it shares the
            // synchronous reset rather than being left as uninitialised storage.
            for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
            ctrl_q <= '0;
            div_q  <= DEFAULT_DIV;
        end else if (wr_en) begin
            if (addr_int < NUM_DIGITS) digit_q[address[IDX_W-1:0]] <= writedata[7:0];
            else if (addr_int == off_ctrl(NUM_DIGITS)) ctrl_q <= writedata[CTRL_W-1:0];
            else if (addr_int == off_div(NUM_DIGITS)) div_q <= writedata[DIV_W-1:0];
        end
    end

    // State register: scan counters plus the registered display outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= '0;
            dig_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking, so the outputs capture the pre-edge index and
            // data; that is what makes them trail idx_q by exactly one cycle.
            presc_q <= presc_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            tick_q  <= tick_d;
        end
    end

    // Next state: >= (not ==) lets a shrunken DIV wrap immediately.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        presc_d = '0;
        idx_d   = '0;
        wrap_d  = 1'b0;
        if (mode == MODE_SCAN) begin
            idx_d = idx_q;
            if (presc_q >= div_q) begin
                wrap_d = (idx_q == LAST_IDX);
                idx_d  = wrap_d ? '0 : idx_q + IDX_W'(1);
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end
    end

    assign digit_sel = digit_q[idx_q];

    seg7_hex_decoder u_hex (
        .nibble_i (digit_sel[3:0]),
        .seg_o    (hex_seg)
    );

`ifdef SEG7_BLINK_EN
    logic [NUM_DIGITS-1:0] mask_q;
    logic [7:0]            bdiv_q, bcnt_q;
    logic                  phase_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q  <= '0;
            bdiv_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            if (wr_en && addr_int == off_blink(NUM_DIGITS)) begin
                mask_q <= writedata[NUM_DIGITS-1:0];
                bdiv_q <= writedata[23:16];
            end
            if (wrap_d) begin
                if (bcnt_q >= bdiv_q) begin
                    bcnt_q  <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    bcnt_q <= bcnt_q + 8'd1;
                end
            end
        end
    end

    assign blank = phase_q && mask_q[idx_q];
`else
    assign blank = 1'b0;
`endif

    // Output decode for the digit currently selected by idx_q.
    always_comb begin
        seg_d  = '0;
        dig_d  = '0;
        tick_d = 1'b0;
        if (mode == MODE_SCAN) begin
            if (ctrl_q[CTRL_HEX_BIT]) begin
                seg_d[SEG_G:SEG_A] = hex_seg;
                seg_d[SEG_DP]      = digit_sel[7];
            end else begin
                seg_d = digit_sel;
            end
            if (blank) seg_d = '0;
            dig_d[idx_q] = 1'b1;
            tick_d       = wrap_q;
        end
    end

    always_comb begin
        readdata = '0;
        if (addr_int < NUM_DIGITS) readdata[7:0] = digit_q[address[IDX_W-1:0]];
        else if (addr_int == off_ctrl(NUM_DIGITS)) readdata[CTRL_W-1:0] = ctrl_q;
        else if (addr_int == off_div(NUM_DIGITS)) readdata[DIV_W-1:0] = div_q;
`ifdef SEG7_BLINK_EN
        else if (addr_int == off_blink(NUM_DIGITS)) begin
            readdata[NUM_DIGITS-1:0] = mask_q;
            readdata[23:16]          = bdiv_q;
        end
`endif
    end

    assign seg_out    = seg_q ^ {8{SEG_ACTIVE_LOW}};
    assign dig_en     = dig_q ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    assign frame_tick = tick_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised successor to the single-byte 7-segment output port: an Avalon-MM slave holding NUM_DIGITS digit registers, driving a time-multiplexed common-segment display.
- Scans one digit at a time from a programmable prescaler.
- Optional on-chip hex decode and configurable output polarity.
- Sits on the Nios II system interconnect; pins go straight to the board display.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- ADDR_W, 4, Avalon address width; must satisfy NUM_DIGITS+3 <= 2**ADDR_W.
- DIV_W, 16, prescaler width.
- DEFAULT_DIV, 16'd49999, prescaler reload value after reset (1 ms per digit at 50 MHz).
- SEG_ACTIVE_LOW, 1, 1 inverts seg_out at the port.
- DIG_ACTIVE_LOW, 1, 1 inverts dig_en at the port.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- address  in  ADDR_W  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; zero wait states.
- seg_out  out  8  segments: bit0=a .. bit6=g, bit7=dp.
- dig_en  out  NUM_DIGITS  one-hot digit enable.
- frame_tick  out  1  1-cycle pulse when the scan index wraps to 0.

Behaviour:
- One clock; reset_n is sampled only on posedge clk, synchronous, active-low. Every register clears in that cycle.
- Register map (word offsets):
  - 0..NUM_DIGITS-1 DIGITn[7:0].
  - NUM_DIGITS CTRL: bit0 EN, bit1 HEX.
  - NUM_DIGITS+1 DIV[DIV_W-1:0].
  - NUM_DIGITS+2 BLINK (see Optional Feature).
  - Unmapped offsets read 0; writes to them are ignored.
- Write:
  - Occurs when chipselect && !write_n.
  - The register updates on that clock edge and is visible on reads from the next cycle.
  - Unused writedata bits are ignored.
- Read:
  - readdata is combinational from address, zero-extended; not gated by chipselect.
  - Read-before-write ordering in the same cycle returns the old value.
- Reset values:
  - DIGITn=0, CTRL=0, DIV=DEFAULT_DIV, scan index=0, prescaler=0.
  - seg_out and dig_en at their inactive level (all segments off, no digit enabled); frame_tick=0.
- Scan states:
  - IDLE (EN=0): prescaler and index are held at 0; outputs are inactive.
  - SCAN (EN=1): prescaler increments each cycle. When prescaler >= DIV, it returns to 0 and index advances modulo NUM_DIGITS.
  - DIV=0 advances the index every cycle.
  - Writing a DIV smaller than the current count forces a wrap on the next cycle; no stall or overrun is allowed.
- Outputs are registered, 1 cycle after the index/data they reflect.
  - Digit pattern: HEX=1 gives hex7seg(DIGITn[3:0]) with dp=DIGITn[7]; HEX=0 gives raw DIGITn[7:0].
  - Polarity inversion is applied after the output register.
- frame_tick:
  - Asserted for exactly one cycle, in the same cycle dig_en moves from digit NUM_DIGITS-1 to digit 0.
  - NUM_DIGITS=1 pulses once per prescaler period.
- Clearing EN mid-scan: the next cycle has outputs inactive and index/prescaler at 0. Setting EN again restarts at digit 0.
- A DIGITn write while digit n is displayed appears on seg_out 1 cycle after the write edge (registered output path).
- Reset asserted mid-scan: all state returns to reset values at that edge; no partial frame completes.

Optional Feature:
- Macro: SEG7_BLINK_EN.
- Defined:
  - BLINK[NUM_DIGITS-1:0] mask and BLINK[23:16] frame divisor BDIV are added.
  - A phase bit toggles every BDIV+1 frame_ticks.
  - While phase=1, digits whose mask bit is set output all-segments-off, but their dig_en is still driven.
  - Reset: mask=0, BDIV=0, phase=0.
- Not defined: offset NUM_DIGITS+2 reads 0, writes are ignored, and no blink logic is synthesised.

Decomposition:
- Package seg7_pkg holds:
  - register offset function/constants relative to NUM_DIGITS;
  - CTRL bit positions (CTRL_EN_BIT=0, CTRL_HEX_BIT=1);
  - segment bit-index constants;
  - the hex-to-segment lookup (16 entries, active-high).
- One sub-module: seg7_hex_decoder (4-bit nibble in, 7-bit a..g out, purely combinational), instantiated once on the selected digit.

Test Plan:
- Reset (defaults, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1) -> seg_out=8'hFF, dig_en=4'hF, frame_tick=0; read DIV -> 49999.
- Write DIGIT0..3=8'h3F,06,5B,4F; DIV=3; CTRL=1 -> dig_en cycles digit0..3 every 4 clocks; seg_out=~DIGITn; frame_tick pulses every 16 clocks.
- CTRL=3 (HEX), DIGIT2=8'h8A -> while digit 2 is active, seg_out=~8'hF7 (A pattern 0x77 plus dp).
- Scanning with DIV=100, prescaler at 50; write DIV=10 -> index advances on the next cycle, then every 11 clocks.
- Clear EN while on digit 2 -> next cycle all outputs inactive; re-enable -> digit 0 first; reset_n low mid-frame -> reset values at the next edge.
- With SEG7_BLINK_EN: BLINK=32'h0001_0002, DIV=0 -> digit 1 is blanked for 2 frames, then shown for 2 frames, repeating. Without the macro, BLINK reads 0 and digit 1 is never blanked.
